// File: rtl/game_ctrl_pkg.sv
// Shared types and constants for the pong game controller and its display.
// No logic; state encodings, winner codes, screen geometry, score helper.
// Imported by game_ctrl and its display peers.
package game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    // Display geometry shared with the video and paddle blocks
    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int PADDLE_W  = 8;
    localparam int PADDLE_H  = 64;
    localparam int BALL_SIZE = 8;

    // Score increment that never passes the match limit
    function automatic logic [3:0] score_inc(input logic [3:0] sc, input logic [3:0] lim);
        return (sc >= lim) ? sc : sc + 4'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Start key conditioner: 2-flop sync, stable-level debounce, press edge detect.
// Latency: 2 sync cycles + DB_CYCLES stable cycles + 1 cycle to the press pulse.
// No backpressure; press is a single-cycle pulse per debounced high-to-low edge.
module key_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Synchronise, count consecutive cycles the input differs from the
    // accepted level, and accept the new level once it has held long enough.
    // Reset leaves the key in its released (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                cnt    <= '0;
                // Only a released-to-pressed change produces a pulse
                press  <= stable;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Pong match controller: serve/play/point pauses, scoring, winner, paddle speed.
// Latency: all outputs registered, one vga_clk after the causing input.
// No backpressure; hit/miss/tick pulses are consumed in the cycle they appear.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_FRAMES = 60,
    parameter int FAST_HITS    = 8,
    parameter int DB_CYCLES    = 500000
) (
    input  logic       vga_clk,
    input  logic       sys_rst,
    input  logic       start_key,
    input  logic       fast_sw,
    input  logic       frame_tick,
    input  logic       hit_l,
    input  logic       hit_r,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic       guiwei,
    output logic       s,
    output logic       ball_en,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam logic [3:0] WIN = 4'(WIN_SCORE);
    localparam logic [7:0] PF  = 8'(PAUSE_FRAMES);
    localparam logic [7:0] FH  = 8'(FAST_HITS);

    state_t     st;
    logic [7:0] pause_cnt;
    logic [7:0] rally_cnt;
    logic       start_pulse;

    key_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_key_debounce (
        .clk   (vga_clk),
        .rst   (sys_rst),
        .key_n (start_key),
        .press (start_pulse)
    );

    assign state = st;

    // Match FSM with registered outputs; every transition sets the outputs
    // of the state it enters, so a pause counter loaded on entry never sees
    // the frame_tick of that same edge.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            st        <= ST_IDLE;
            guiwei    <= 1'b1;
            ball_en   <= 1'b0;
            s         <= fast_sw;
            serve_dir <= 1'b1;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            winner    <= WIN_NONE;
            pause_cnt <= 8'd0;
            rally_cnt <= 8'd0;
        end else begin
            s <= fast_sw | ((st == ST_PLAY) && (rally_cnt == FH));
            case (st)
                ST_IDLE, ST_OVER: begin
                    if (start_pulse) begin
                        st        <= ST_SERVE;
                        score_l   <= 4'd0;
                        score_r   <= 4'd0;
                        winner    <= WIN_NONE;
                        serve_dir <= 1'b1;
                        pause_cnt <= PF;
                    end
                end
                ST_SERVE: begin
                    if (pause_cnt == 8'd0) begin
                        st        <= ST_PLAY;
                        guiwei    <= 1'b0;
                        ball_en   <= 1'b1;
                        rally_cnt <= 8'd0;
                    end else if (frame_tick) begin
                        pause_cnt <= pause_cnt - 8'd1;
                    end
                end
                ST_PLAY: begin
                    // A miss ends the rally and masks any hit in the same cycle
                    if (miss_l || miss_r) begin
                        st        <= ST_POINT;
                        guiwei    <= 1'b1;
                        ball_en   <= 1'b0;
                        pause_cnt <= PF;
                        if (miss_l && !miss_r) begin
                            score_r   <= score_inc(score_r, WIN);
                            serve_dir <= 1'b0;
                        end else if (miss_r && !miss_l) begin
                            score_l   <= score_inc(score_l, WIN);
                            serve_dir <= 1'b1;
                        end
                    end else if ((hit_l || hit_r) && (rally_cnt != FH)) begin
                        rally_cnt <= rally_cnt + 8'd1;
                    end
                end
                ST_POINT: begin
                    if (pause_cnt == 8'd0) begin
                        if (score_l == WIN) begin
                            winner <= WIN_LEFT;
                            st     <= ST_OVER;
                        end else if (score_r == WIN) begin
                            winner <= WIN_RIGHT;
                            st     <= ST_OVER;
                        end else begin
                            st        <= ST_SERVE;
                            pause_cnt <= PF;
                        end
                    end else if (frame_tick) begin
                        pause_cnt <= pause_cnt - 8'd1;
                    end
                end
                default: begin
                    st      <= ST_IDLE;
                    guiwei  <= 1'b1;
                    ball_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed sequences, event table, randomized traffic.
// Every cycle is also compared against a rule-level reference model.
// Inputs are driven 1ns after the rising edge and outputs sampled there.
module tb_game_ctrl;

    localparam int W  = 3;
    localparam int PF = 2;
    localparam int FH = 4;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key = 1'b1;
    logic       fsw = 1'b0;
    logic       tick = 1'b0;
    logic       hl = 1'b0, hr = 1'b0, ml = 1'b0, mr = 1'b0;
    logic       guiwei, s, ball_en, serve_dir;
    logic [3:0] score_l, score_r;
    logic [1:0] winner;
    logic [2:0] state;

    int ntests = 0;
    int nfail  = 0;
    int cyc_n  = 0;

    always #5 clk = ~clk;

    game_ctrl #(
        .WIN_SCORE(W), .PAUSE_FRAMES(PF), .FAST_HITS(FH), .DB_CYCLES(DB)
    ) dut (
        .vga_clk(clk), .sys_rst(rst), .start_key(key), .fast_sw(fsw),
        .frame_tick(tick), .hit_l(hl), .hit_r(hr), .miss_l(ml), .miss_r(mr),
        .guiwei(guiwei), .s(s), .ball_en(ball_en), .serve_dir(serve_dir),
        .score_l(score_l), .score_r(score_r), .winner(winner), .state(state)
    );

    // Reference model: phase numbers follow the documented encodings,
    // scores kept per side (0 = left, 1 = right).
    int m_ph = 0, m_wait = 0, m_hits = 0, m_win = 0, m_run = 0;
    int m_sc[2] = '{0, 0};
    bit m_dir = 1'b1, m_s = 1'b0;
    bit m_k1 = 1'b1, m_k2 = 1'b1, m_stable = 1'b1, m_sp = 1'b0;

    task automatic model_step();
        bit sp_now;
        bit s_new;
        if (rst) begin
            m_ph = 0; m_wait = 0; m_hits = 0; m_win = 0; m_sc = '{0, 0};
            m_dir = 1'b1; m_s = fsw;
            m_k1 = 1'b1; m_k2 = 1'b1; m_stable = 1'b1; m_run = 0; m_sp = 1'b0;
            return;
        end
        sp_now = m_sp;
        s_new  = fsw || (m_ph == 2 && m_hits == FH);
        case (m_ph)
            0, 4: if (sp_now) begin
                m_ph = 1; m_sc = '{0, 0}; m_win = 0; m_dir = 1'b1; m_wait = PF;
            end
            1: begin
                if (m_wait == 0) begin m_ph = 2; m_hits = 0; end
                else if (tick) m_wait--;
            end
            2: begin
                if (ml || mr) begin
                    m_ph = 3; m_wait = PF;
                    if (ml && !mr) begin
                        if (m_sc[1] < W) m_sc[1]++;
                        m_dir = 1'b0;
                    end else if (mr && !ml) begin
                        if (m_sc[0] < W) m_sc[0]++;
                        m_dir = 1'b1;
                    end
                end else if ((hl || hr) && m_hits < FH) begin
                    m_hits++;
                end
            end
            3: begin
                if (m_wait == 0) begin
                    if (m_sc[0] == W) begin m_win = 1; m_ph = 4; end
                    else if (m_sc[1] == W) begin m_win = 2; m_ph = 4; end
                    else begin m_ph = 1; m_wait = PF; end
                end else if (tick) m_wait--;
            end
            default: m_ph = 0;
        endcase
        // Start key: synced level is the raw key two edges late; accepted
        // once it has differed from the held level for DB consecutive edges.
        m_sp = 1'b0;
        if (m_k2 != m_stable) begin
            m_run++;
            if (m_run == DB) begin
                m_sp = m_stable; m_stable = m_k2; m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_k2 = m_k1;
        m_k1 = key;
        m_s  = s_new;
    endtask

    task automatic cyc();
        logic [16:0] got;
        logic [16:0] exp;
        @(posedge clk);
        model_step();
        #1;
        cyc_n++;
        got = {state, guiwei, ball_en, s, serve_dir, score_l, score_r, winner};
        exp = {3'(m_ph), (m_ph != 2), (m_ph == 2), m_s, m_dir,
               4'(m_sc[0]), 4'(m_sc[1]), 2'(m_win)};
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL model cycle=%0d got=%h expected=%h (state,gw,ben,s,dir,sl,sr,win)",
                     cyc_n, got, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        ntests++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(); rst = 1'b0;
    endtask

    task automatic start_game();
        key = 1'b0; repeat (6) cyc(); key = 1'b1; cyc();
    endtask

    task automatic tick_cyc();
        tick = 1'b1; cyc(); tick = 1'b0;
    endtask

    task automatic pause_through();
        tick_cyc(); tick_cyc(); cyc();
    endtask

    task automatic pulse(input logic [3:0] ev);
        {hl, hr, ml, mr} = ev; cyc(); {hl, hr, ml, mr} = 4'b0000;
    endtask

    typedef struct {
        logic [3:0] ev;
        logic [2:0] st;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       dir;
    } vec_t;
    vec_t  vecs[8];
    string vname[8];
    int    nv = 0;

    task automatic add_vec(input string n, input logic [3:0] ev, input logic [2:0] st,
                           input logic [3:0] sl, input logic [3:0] sr, input logic dir);
        vecs[nv].ev = ev; vecs[nv].st = st; vecs[nv].sl = sl;
        vecs[nv].sr = sr; vecs[nv].dir = dir; vname[nv] = n; nv++;
    endtask

    initial begin
        int kcnt;
        // {hit_l, hit_r, miss_l, miss_r} applied once in a fresh PLAY
        add_vec("miss_l",       4'b0010, 3'd3, 4'd0, 4'd1, 1'b0);
        add_vec("miss_r",       4'b0001, 3'd3, 4'd1, 4'd0, 1'b1);
        add_vec("miss_both",    4'b0011, 3'd3, 4'd0, 4'd0, 1'b1);
        add_vec("hit_l_miss_r", 4'b1001, 3'd3, 4'd1, 4'd0, 1'b1);
        add_vec("hit_r_miss_l", 4'b0110, 3'd3, 4'd0, 4'd1, 1'b0);
        add_vec("hit_l",        4'b1000, 3'd2, 4'd0, 4'd0, 1'b1);
        add_vec("hit_both",     4'b1100, 3'd2, 4'd0, 4'd0, 1'b1);
        add_vec("quiet",        4'b0000, 3'd2, 4'd0, 4'd0, 1'b1);

        // Reset values, including s following fast_sw
        rst = 1'b1; fsw = 1'b1; cyc();
        chk("rst_s_follows_sw", s, 1);
        fsw = 1'b0; cyc(); rst = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_guiwei", guiwei, 1);
        chk("rst_ball_en", ball_en, 0);
        chk("rst_serve_dir", serve_dir, 1);
        chk("rst_scores", {score_l, score_r}, 0);
        chk("rst_winner", winner, 0);
        chk("rst_s", s, 0);

        // Start press: six low cycles, entry edge carries a frame_tick
        key = 1'b0; repeat (6) cyc(); key = 1'b1;
        chk("start_not_yet", state, 0);
        tick_cyc();
        chk("start_serve", state, 1);
        chk("serve_guiwei", guiwei, 1);
        pulse(4'b0010);
        chk("serve_miss_ignored", score_r, 0);
        repeat (8) cyc();
        chk("single_start_pulse", state, 1);
        tick_cyc(); cyc();
        chk("entry_tick_not_counted", state, 1);
        tick_cyc();
        chk("pause_zero_still_serve", state, 1);
        cyc();
        chk("play_state", state, 2);
        chk("play_ball_en", ball_en, 1);
        chk("play_guiwei", guiwei, 0);

        // Fast speed after FH hits, then a left miss
        repeat (3) begin pulse(4'b0100); cyc(); end
        pulse(4'b0100);
        chk("s_low_on_4th_hit", s, 0);
        cyc();
        chk("s_high_after_4th", s, 1);
        pulse(4'b0010);
        chk("miss_l_score_r", score_r, 1);
        chk("miss_l_dir", serve_dir, 0);
        chk("miss_l_point", state, 3);
        cyc();
        chk("s_drop_in_point", s, 0);

        // Double miss, then hit_l with miss_r in a later rally
        pause_through(); pause_through();
        pulse(4'b0011);
        chk("dbl_miss_point", state, 3);
        chk("dbl_miss_scores", {score_l, score_r}, 8'h01);
        chk("dbl_miss_dir", serve_dir, 0);
        pause_through(); pause_through();
        pulse(4'b1001);
        chk("hit_miss_score_l", score_l, 1);
        chk("hit_miss_dir", serve_dir, 1);

        // Right side takes the match
        pause_through(); pause_through();
        pulse(4'b0010);
        pause_through(); pause_through();
        pulse(4'b0010);
        chk("sr_three", score_r, 3);
        tick_cyc(); tick_cyc();
        chk("over_not_yet", state, 3);
        cyc();
        chk("over_state", state, 4);
        chk("over_winner", winner, 2);
        chk("over_score_r", score_r, 3);
        pulse(4'b0010);
        chk("over_miss_ignored", score_r, 3);
        start_game();
        chk("restart_state", state, 1);
        chk("restart_scores", {score_l, score_r}, 0);
        chk("restart_winner", winner, 0);
        chk("restart_dir", serve_dir, 1);

        // Reset mid-rally with score_l=2; the miss in the reset cycle is lost
        pause_through();
        pulse(4'b0001); pause_through(); pause_through();
        pulse(4'b0001); pause_through(); pause_through();
        chk("pre_rst_score_l", score_l, 2);
        chk("pre_rst_play", state, 2);
        rst = 1'b1; mr = 1'b1; cyc(); rst = 1'b0; mr = 1'b0;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_scores", {score_l, score_r}, 0);
        chk("mid_rst_guiwei", guiwei, 1);
        chk("mid_rst_ball_en", ball_en, 0);

        // Single-cycle event table from a fresh rally
        for (int i = 0; i < nv; i++) begin
            do_reset(); start_game(); pause_through();
            pulse(vecs[i].ev);
            chk({vname[i], "_state"}, state, vecs[i].st);
            chk({vname[i], "_score_l"}, score_l, vecs[i].sl);
            chk({vname[i], "_score_r"}, score_r, vecs[i].sr);
            chk({vname[i], "_dir"}, serve_dir, vecs[i].dir);
            chk({vname[i], "_ball_en"}, ball_en, (vecs[i].st == 3'd2));
        end

        // Randomized traffic checked only by the model
        do_reset();
        kcnt = 0;
        for (int i = 0; i < 5000; i++) begin
            rst  = ($urandom_range(0, 799) == 0);
            tick = ($urandom_range(0, 2) == 0);
            hl   = ($urandom_range(0, 3) == 0);
            hr   = ($urandom_range(0, 3) == 0);
            ml   = ($urandom_range(0, 24) == 0);
            mr   = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 99) == 0) fsw = ~fsw;
            if (kcnt == 0) begin
                key  = ($urandom_range(0, 3) != 0);
                kcnt = $urandom_range(1, 12);
            end else begin
                kcnt--;
            end
            cyc();
        end
        rst = 1'b0; tick = 1'b0; {hl, hr, ml, mr} = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
